// File: rtl/serial_alu.sv
// Bit-serial ALU: AND/OR/ADD/SUB processed LSB-first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] o,
   output logic             c_out,
   output logic             zero,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

   state_t           state, next_state;
   op_t              op_r;
   logic [WIDTH-1:0] a_sh;   // operand A in, result bits shifted in from the top
   logic [WIDTH-1:0] b_sh;
   logic [CW-1:0]    cnt;
   logic             carry;

   logic             b_bit;
   logic             slice_bit;
   logic             carry_nxt;
   logic             arith;
   logic             last_bit;
   logic [WIDTH-1:0] res_nxt;

   // One-bit slice
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      b_bit     = (op_r == OP_SUB) ? ~b_sh[0] : b_sh[0];
      slice_bit = 1'b0;
      carry_nxt = carry;
      arith     = (op_r == OP_ADD) || (op_r == OP_SUB);
      case (op_r)
         OP_AND:  slice_bit = a_sh[0] & b_bit;
         OP_OR:   slice_bit = a_sh[0] | b_bit;
         default: begin
            slice_bit = a_sh[0] ^ b_bit ^ carry;
            carry_nxt = (a_sh[0] & b_bit) | (a_sh[0] & carry) | (b_bit & carry);
         end
      endcase
      res_nxt  = {slice_bit, a_sh[WIDTH-1:1]};
      last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) next_state = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) next_state = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r  <= OP_AND;
         a_sh  <= '0;
         b_sh  <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         o     <= '0;
         c_out <= 1'b0;
         zero  <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         case (state)
            IDLE: if (start) begin
               a_sh  <= a;
               b_sh  <= b;
               op_r  <= op_t'(operation);
               cnt   <= '0;
               carry <= (operation == OP_SUB);  // two's-complement +1 for a-b
            end
            RUN: begin
               a_sh  <= res_nxt;
               b_sh  <= b_sh >> 1;
               carry <= carry_nxt;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  o     <= res_nxt;
                  c_out <= arith & carry_nxt;
                  zero  <= (res_nxt == '0);
`ifdef SERIAL_ALU_OVF_EN
                  // carry into the MSB differs from carry out of it
                  ovf   <= arith & (carry ^ carry_nxt);
`endif
               end
            end
            default: ;
         endcase
      end
   end

`ifndef SERIAL_ALU_OVF_EN
   assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range is 2..32.
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004: start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005: operation  input  2  SHALL select the operation: 00 AND, 01 OR, 10 ADD, 11 SUB (a-b).
REQ-006: a  input  WIDTH  SHALL be operand A, captured with start.
REQ-007: b  input  WIDTH  SHALL be operand B, captured with start.
REQ-008: busy  output  1  SHALL be high in RUN and DONE.
REQ-009: done  output  1  SHALL pulse for one cycle when the result is valid.
REQ-010: o  output  WIDTH  SHALL be the registered result.
REQ-011: c_out  output  1  SHALL be the registered carry-out.
REQ-012: zero  output  1  SHALL be high when o == 0 at completion.
REQ-013: ovf  output  1  SHALL be the signed-overflow flag (see Configuration).

Function
REQ-014: The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015: At a clock edge in IDLE with start=1, the block SHALL capture a, b and operation, clear the bit counter, preset carry (1 for SUB, else 0), and go to RUN.
REQ-016: In RUN, each edge SHALL process one bit LSB-first through a 1-bit slice; for SUB the slice uses ~b[i].
REQ-017: The slice SHALL form sum = a^b'^c, carry = majority(a,b',c); for AND/OR the bit is a&b / a|b and carry is unchanged.
REQ-018: After the edge processing bit WIDTH-1, the FSM SHALL go to DONE and load o, c_out, zero and ovf in the same edge; done=1 for exactly that cycle.
REQ-019: Latency: with start sampled at edge t, done SHALL be high between edges t+WIDTH and t+WIDTH+1; the FSM returns to IDLE at edge t+WIDTH+1.
REQ-020: c_out SHALL be the final carry for ADD/SUB (SUB: 1 = no borrow) and 0 for AND/OR.
REQ-021: o, c_out, zero and ovf SHALL hold their values until the next completion; they SHALL NOT change during RUN.
REQ-022: start SHALL be ignored in RUN and DONE, with no queuing; changes to a, b and operation after capture SHALL have no effect.
REQ-023: start held high continuously SHALL launch a new operation on each IDLE cycle, i.e. every WIDTH+2 cycles.

Reset
REQ-024: rst_n=0 SHALL immediately force IDLE and clear busy, done, o, c_out, zero and ovf.
REQ-025: Reset mid-operation SHALL abort the operation without a done pulse; the first edge with rst_n=1 and start=1 SHALL start a new operation normally.

Configuration
REQ-026: With SERIAL_ALU_OVF_EN defined, ovf SHALL be set at completion for ADD/SUB when carry-in to MSB != carry-out of MSB, and 0 for AND/OR.
REQ-027: Without SERIAL_ALU_OVF_EN, port ovf SHALL remain present and tied to 0, and no overflow logic is synthesised.

Verification (WIDTH=8)
REQ-028: ADD a=0xFF, b=0x01, start at edge t -> done at t+8, o=0x00, c_out=1, zero=1, ovf=0.
REQ-029: SUB a=0x05, b=0x07 -> o=0xFE, c_out=0, zero=0, ovf=0; SUB a=0x80, b=0x01 -> o=0x7F, ovf=1 with the macro, 0 without.
REQ-030: AND 0xF0,0x3C -> o=0x30, c_out=0; OR 0xF0,0x3C -> o=0xFC, c_out=0; previous o stays stable throughout RUN.
REQ-031: ADD 0x7F+0x01 -> o=0x80, c_out=0, ovf=1 (macro) / 0 (no macro).
REQ-032: start pulsed again 3 cycles into RUN with different operands -> ignored; one done only, with the first result.
REQ-033: rst_n low 4 cycles into RUN -> busy=0, o=0 asynchronously, no done; a new ADD 0x01+0x01 after release -> o=0x02 after 8 cycles.
